// File: rtl/booth_mult_seq_if.sv
// Handshake bundle for booth_mult_seq.
//   master : requester side (drives start and operands, observes status/product)
//   slave  : multiplier side (observes start and operands, drives status/product)
// Signals:
//   start         request; accepted only while the multiplier is idle or done
//   multiplicand  signed operand M, sampled on the accepting edge
//   multiplier    signed operand Q, sampled on the accepting edge
//   busy          high while a product is being computed
//   done          one-cycle pulse, product valid from that cycle
//   product       signed M*Q, held until the next result is written
//
// Handshake semantics: start is a request, not a valid/ready pair. A request
// is taken on a rising clk edge where start=1 and the multiplier is idle or
// done; a request seen while busy=1 is dropped, not queued. Holding start high
// through the done cycle chains the next operation with no idle gap.
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier, control and datapath in one block.
// One add/sub plus arithmetic shift per clock. Radix-2 by default; defining
// the macro BOOTH_RADIX4_EN selects radix-4 recoding (WIDTH/2 iterations,
// WIDTH must then be even).
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous, active-low reset; aborts any calculation
//   bus        booth_mult_seq_if.slave: start/multiplicand/multiplier in,
//              busy/done/product out
//   dbg_state  current FSM state: 0=IDLE, 1=CALC, 2=DONE
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  booth_mult_seq_if.slave     bus,
  output logic [1:0]          dbg_state
);

`ifdef BOOTH_RADIX4_EN
  localparam int ITER = WIDTH / 2;
  localparam int AW   = WIDTH + 2;  // room for +/-2M without overflow
  if ((WIDTH % 2) != 0) begin : g_odd_width
    $error("booth_mult_seq: WIDTH must be even with radix-4 recoding");
  end
`else
  localparam int ITER = WIDTH;
  localparam int AW   = WIDTH + 1;  // extra bit keeps M=-2^(WIDTH-1) exact
`endif

  if (WIDTH < 2) begin : g_small_width
    $error("booth_mult_seq: WIDTH must be at least 2");
  end

  localparam int CW = $clog2(ITER + 1);
  localparam int SW = AW + WIDTH + 1;  // {A, Q, Qm1}

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [AW-1:0]        a;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     q;
  logic                 qm1;
  logic [CW-1:0]        count;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;

  logic [AW-1:0]        m_ext;
  logic [AW-1:0]        sum;
  logic [SW-1:0]        cat;
  logic [SW-1:0]        shr;
  logic [AW-1:0]        a_next;
  logic [WIDTH-1:0]     q_next;
  logic                 qm1_next;

  assign m_ext = {{(AW-WIDTH){m[WIDTH-1]}}, m};

  // One iteration: recode, add/sub into A, then arithmetic shift of {A,Q,Qm1}.
  always_comb begin
    sum = a;
`ifdef BOOTH_RADIX4_EN
    case ({q[1:0], qm1})
      3'b001, 3'b010: sum = a + m_ext;
      3'b011:         sum = a + {m_ext[AW-2:0], 1'b0};
      3'b100:         sum = a - {m_ext[AW-2:0], 1'b0};
      3'b101, 3'b110: sum = a - m_ext;
      default:        sum = a;
    endcase
    cat = {sum, q, qm1};
    shr = {{2{sum[AW-1]}}, cat[SW-1:2]};
`else
    case ({q[0], qm1})
      2'b01:   sum = a + m_ext;
      2'b10:   sum = a - m_ext;
      default: sum = a;
    endcase
    cat = {sum, q, qm1};
    shr = {sum[AW-1], cat[SW-1:1]};
`endif
    a_next   = shr[SW-1:WIDTH+1];
    q_next   = shr[WIDTH:1];
    qm1_next = shr[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      a         <= '0;
      m         <= '0;
      q         <= '0;
      qm1       <= 1'b0;
      count     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            m      <= bus.multiplicand;
            q      <= bus.multiplier;
            a      <= '0;
            qm1    <= 1'b0;
            count  <= CW'(ITER);
            busy_r <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          a     <= a_next;
          q     <= q_next;
          qm1   <= qm1_next;
          count <= count - 1'b1;
          // Last iteration: the product is taken from the post-shift values.
          if (count == CW'(1)) begin
            product_r <= {a_next[WIDTH-1:0], q_next};
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
  assign dbg_state   = state;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: a WIDTH=8 instance for directed and
// random cases and a WIDTH=16 instance for random cases. Expected products
// come from plain integer multiplication of the signed operands.
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
  localparam int ITER8  = 4;
  localparam int ITER16 = 8;
`else
  localparam int ITER8  = 8;
  localparam int ITER16 = 16;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(8))  bus8 ();
  booth_mult_seq_if #(.WIDTH(16)) bus16 ();
  logic [1:0] dbg_state8;
  logic [1:0] dbg_state16;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus8.slave),
    .dbg_state (dbg_state8)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus16.slave),
    .dbg_state (dbg_state16)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] exp_q[$];
  logic [31:0] exp16_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Issue one op on the 8-bit DUT, optionally pulse start with other operands
  // at negedge mid_k (while CALC), then observe ITER8+3 cycles.
  task automatic run_op8(input logic [7:0] m, input logic [7:0] q,
                         input int mid_k, input logic [7:0] m2, input logic [7:0] q2,
                         output logic [15:0] prod, output int lat,
                         output int busy_cnt, output int pulses);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.multiplicand = m;
    bus8.multiplier = q;
    @(posedge clk);
    lat = -1; busy_cnt = 0; pulses = 0; prod = 'x;
    for (int k = 0; k < ITER8 + 3; k++) begin
      @(negedge clk);
      if (bus8.busy) busy_cnt++;
      if (bus8.done) begin
        pulses++;
        if (lat < 0) lat = k;
        prod = bus8.product;
      end
      if (k == mid_k) begin
        bus8.start = 1'b1;
        bus8.multiplicand = m2;
        bus8.multiplier = q2;
      end else begin
        bus8.start = 1'b0;
        bus8.multiplicand = 8'($urandom);
        bus8.multiplier = 8'($urandom);
      end
    end
    bus8.start = 1'b0;
  endtask

  task automatic run_op16(input logic [15:0] m, input logic [15:0] q,
                          output logic [31:0] prod, output int lat, output int busy_cnt);
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.multiplicand = m;
    bus16.multiplier = q;
    @(posedge clk);
    lat = -1; busy_cnt = 0; prod = 'x;
    for (int k = 0; k < ITER16 + 3; k++) begin
      @(negedge clk);
      bus16.start = 1'b0;
      if (bus16.busy) busy_cnt++;
      if (bus16.done && lat < 0) begin
        lat = k;
        prod = bus16.product;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus8.start = 1'b1;  // start during reset must be ignored
    bus16.start = 1'b1;
    bus8.multiplicand = 8'd5;  bus8.multiplier = 8'd5;
    bus16.multiplicand = 16'd5; bus16.multiplier = 16'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus8.busy, bus8.done, bus8.product} !== 18'd0) $display("FAIL reset8: busy=%b done=%b product=%h, want 0 0 0000", bus8.busy, bus8.done, bus8.product);
    else pass_cnt++;
    total_cnt++;
    if ({bus16.busy, bus16.done, bus16.product} !== 34'd0) $display("FAIL reset16: busy=%b done=%b product=%h, want 0 0 0", bus16.busy, bus16.done, bus16.product);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state8 !== 2'd0) $display("FAIL reset_state: got %0d want 0 (IDLE)", dbg_state8);
    else pass_cnt++;
    bus8.start = 1'b0;
    bus16.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus8.busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", bus8.busy);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [7:0]  ms[5] = '{8'd5, 8'h80, 8'h80, 8'd0, 8'h7F};
    logic [7:0]  qs[5] = '{8'hFD, 8'h80, 8'h7F, 8'h9C, 8'd0};
    logic [15:0] ps[5] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0000, 16'h0000};
    logic [15:0] prod;
    int lat, bc, pc;
    for (int i = 0; i < 5; i++) begin
      run_op8(ms[i], qs[i], -1, 8'd0, 8'd0, prod, lat, bc, pc);
      total_cnt++;
      if (prod !== ps[i]) $display("FAIL directed_product[%0d]: got %h want %h", i, prod, ps[i]);
      else pass_cnt++;
      total_cnt++;
      if (lat !== ITER8) $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, ITER8);
      else pass_cnt++;
      total_cnt++;
      if (bc !== ITER8 || pc !== 1) $display("FAIL directed_busy_done[%0d]: busy=%0d done=%0d want %0d 1", i, bc, pc, ITER8);
      else pass_cnt++;
      total_cnt++;
      if (bus8.product !== ps[i]) $display("FAIL directed_hold[%0d]: got %h want %h", i, bus8.product, ps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    logic [15:0] prod;
    int lat, bc, pc;
    run_op8(8'd9, 8'hF9, 1, 8'd100, 8'd3, prod, lat, bc, pc);
    total_cnt++;
    if (prod !== 16'hFFC1) $display("FAIL ignore_start_product: got %h want ffc1", prod);
    else pass_cnt++;
    total_cnt++;
    if (pc !== 1 || bc !== ITER8) $display("FAIL ignore_start_pulses: done=%0d busy=%0d want 1 %0d", pc, bc, ITER8);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int busy_total = 0;
    int done_at[$];
    logic [15:0] prods[$];
    logic busy_at_done = 1'b1;
    logic busy_after = 1'b0;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.multiplicand = 8'd3;
    bus8.multiplier = 8'd4;
    @(posedge clk);
    for (int k = 0; k < 2 * ITER8 + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus8.multiplicand = 8'hF9;  // -7
        bus8.multiplier = 8'd6;
      end
      if (bus8.busy) busy_total++;
      if (k == ITER8) busy_at_done = bus8.busy;
      if (k == ITER8 + 1) begin
        busy_after = bus8.busy;
        bus8.start = 1'b0;
      end
      if (bus8.done) begin
        pulses++;
        done_at.push_back(k);
        prods.push_back(bus8.product);
      end
    end
    bus8.start = 1'b0;
    total_cnt++;
    if (pulses !== 2) $display("FAIL b2b_pulses: got %0d want 2", pulses);
    else pass_cnt++;
    if (pulses == 2) begin
      total_cnt++;
      if (prods[0] !== 16'd12 || prods[1] !== 16'hFFD6) $display("FAIL b2b_products: got %h %h want 000c ffd6", prods[0], prods[1]);
      else pass_cnt++;
      total_cnt++;
      if (done_at[0] !== ITER8 || done_at[1] !== 2 * ITER8 + 1) $display("FAIL b2b_done_times: got %0d %0d want %0d %0d", done_at[0], done_at[1], ITER8, 2 * ITER8 + 1);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy_at_done !== 1'b0 || busy_after !== 1'b1 || busy_total !== 2 * ITER8) $display("FAIL b2b_busy: at_done=%b after=%b total=%0d want 0 1 %0d", busy_at_done, busy_after, busy_total, 2 * ITER8);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_calc();
    int pulses = 0;
    int bc = 0;
    int lat, pc;
    logic [15:0] prod;
    logic [15:0] e;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.multiplicand = 8'd37;
    bus8.multiplier = 8'hF5;  // -11
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);   // now at k=3, four iterations into CALC after the next edge
    rst = 1'b0;
    bus8.start = 1'b1;           // coincident with reset: must be ignored
    @(negedge clk);
    total_cnt++;
    if ({bus8.busy, bus8.done, bus8.product} !== 18'd0 || dbg_state8 !== 2'd0) $display("FAIL mid_reset_state: busy=%b done=%b product=%h state=%0d want 0 0 0000 0", bus8.busy, bus8.done, bus8.product, dbg_state8);
    else pass_cnt++;
    rst = 1'b1;
    bus8.start = 1'b0;
    for (int k = 0; k < ITER8 + 2; k++) begin
      @(negedge clk);
      if (bus8.done) pulses++;
      if (bus8.busy) bc++;
    end
    total_cnt++;
    if (pulses !== 0 || bc !== 0) $display("FAIL mid_reset_quiet: done=%0d busy=%0d want 0 0", pulses, bc);
    else pass_cnt++;
    e = 16'(longint'(37) * longint'(-11));
    run_op8(8'd37, 8'hF5, -1, 8'd0, 8'd0, prod, lat, bc, pc);
    total_cnt++;
    if (prod !== e || lat !== ITER8) $display("FAIL mid_reset_recover: product=%h lat=%0d want %h %0d", prod, lat, e, ITER8);
    else pass_cnt++;
  endtask

  task automatic test_random8();
    logic [7:0]  m, q;
    logic [15:0] prod, e;
    int lat, bc, pc;
    for (int i = 0; i < 24; i++) begin
      m = 8'($urandom_range(0, 255));
      q = 8'($urandom_range(0, 255));
      exp_q.push_back(16'(longint'($signed(m)) * longint'($signed(q))));
      run_op8(m, q, -1, 8'd0, 8'd0, prod, lat, bc, pc);
      e = exp_q.pop_front();
      total_cnt++;
      if (prod !== e) $display("FAIL random8_product: M=%0d Q=%0d got %h want %h", $signed(m), $signed(q), prod, e);
      else pass_cnt++;
      total_cnt++;
      if (bc !== ITER8 || lat !== ITER8 || pc !== 1) $display("FAIL random8_timing: busy=%0d lat=%0d done=%0d want %0d %0d 1", bc, lat, pc, ITER8, ITER8);
      else pass_cnt++;
    end
  endtask

  task automatic test_random16();
    logic [15:0] m, q;
    logic [31:0] prod, e;
    int lat, bc;
    for (int i = 0; i < 16; i++) begin
      m = 16'($urandom);
      q = 16'($urandom);
      if (i == 0) begin m = 16'h8000; q = 16'h8000; end
      exp16_q.push_back(32'(longint'($signed(m)) * longint'($signed(q))));
      run_op16(m, q, prod, lat, bc);
      e = exp16_q.pop_front();
      total_cnt++;
      if (prod !== e) $display("FAIL random16_product: M=%0d Q=%0d got %h want %h", $signed(m), $signed(q), prod, e);
      else pass_cnt++;
      total_cnt++;
      if (bc !== ITER16 || lat !== ITER16) $display("FAIL random16_timing: busy=%0d lat=%0d want %0d %0d", bc, lat, ITER16, ITER16);
      else pass_cnt++;
    end
  endtask

  initial begin
    bus8.start = 1'b0;
    bus8.multiplicand = '0;
    bus8.multiplier = '0;
    bus16.start = 1'b0;
    bus16.multiplicand = '0;
    bus16.multiplier = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_calc();
    test_random8();
    test_random16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
